// File: rtl/dot_accumulator.sv
// Streams (weight, activation) pairs for one gate row, accumulates full-precision
// products and emits a rescaled, saturated dot-product word tagged with its row index.
module dot_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 12,
    parameter int VEC_LEN    = 8,
    parameter int NUM_ROWS   = 4,
    parameter int ACC_WIDTH  = 36,
    localparam int IDX_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CNT_W     = $clog2(VEC_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic [IDX_W-1:0]      out_index
);

    // state | meaning
    // ACC   | accepting element pairs of the current row
    // HOLD  | completed row presented, waiting for out_ready
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]              elem_cnt_q, elem_cnt_d;
    logic [IDX_W-1:0]              out_index_q, out_index_d;
    logic                          out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]         out_sum_q, out_sum_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_sum;
    logic signed [ACC_WIDTH-1:0]    scaled;
    logic [DATA_WIDTH-1:0]          sat_sum;
    logic                           accept;

    assign prod    = $signed(in_a) * $signed(in_b);
    assign acc_sum = acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    // Arithmetic shift floors toward negative infinity; no rounding is applied.
    assign scaled  = acc_sum >>> FRAC_WIDTH;
    assign accept  = in_valid && (state_q == ACC);

    always_comb begin
        sat_sum = scaled[DATA_WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            sat_sum = SAT_MAX[DATA_WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_sum = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            elem_cnt_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            elem_cnt_q  <= elem_cnt_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        elem_cnt_d  = elem_cnt_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = acc_sum;
                    if (elem_cnt_q == CNT_W'(VEC_LEN-1)) begin
                        elem_cnt_d  = '0;
                        out_sum_d   = sat_sum;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // out_sum is left as-is on handoff; out_valid alone qualifies it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    out_index_d = (out_index_q == IDX_W'(NUM_ROWS-1)) ? '0 : out_index_q + 1'b1;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = out_valid_q;
        out_sum   = out_sum_q;
        out_index = out_index_q;
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: unit rows, saturation, truncation,
// backpressure, index wrap and asynchronous reset mid-row.
module tb_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [1:0]  out_index;

    int total = 0;
    int bad   = 0;

    dot_accumulator #(
        .DATA_WIDTH(16),
        .FRAC_WIDTH(12),
        .VEC_LEN   (4),
        .NUM_ROWS  (3),
        .ACC_WIDTH (36)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_index(out_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends one row of VEC_LEN identical beats, optionally with idle gaps,
    // checks the result, optionally holds out_ready low, then hands off.
    task automatic run_row(input string tag, input int a, input int b, input bit gap,
                           input int hold, input int exp_sum, input int exp_idx);
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] ev;
        av = a;
        bv = b;
        ev = exp_sum;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = av[15:0];
            in_b     = bv[15:0];
            chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
            @(posedge clk);
            if (gap && i < 3) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = (hold > 0);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum), 32'(ev[15:0]));
        chk({tag, "_idx"}, 32'(out_index), 32'(exp_idx));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(out_sum), 32'(ev[15:0]));
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_done_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_idx", 32'(out_index), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        run_row("unit",     4096,  4096,  1'b0, 0, 16384,  0);
        run_row("sat_pos",  32767, 32767, 1'b0, 0, 32767,  1);
        run_row("neg_min",  -4096, 8192,  1'b0, 0, -32768, 2);
        run_row("sat_neg",  -4096, 12288, 1'b0, 0, -32768, 0);
        run_row("trunc_p",  1,     1,     1'b1, 0, 0,      1);
        run_row("trunc_n",  -1,    1,     1'b0, 0, -1,     2);

        run_row("bp",       4096,  4096,  1'b0, 5, 16384,  0);
        run_row("wrap1",    2048,  4096,  1'b0, 0, 8192,   1);
        run_row("wrap2",    -2048, 4096,  1'b1, 0, -8192,  2);
        run_row("wrap0",    4096,  -4096, 1'b0, 0, -16384, 0);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'd4096;
            in_b     = 16'd4096;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_idx", 32'(out_index), 32'd0);
        #1 rst = 1'b0;
        run_row("post_rst", 4096,  4096,  1'b0, 0, 16384,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
